spm_param_commit: RTL
=====================

SPM_PARAM_COMMIT -- requirements
Module: spm_param_commit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of every parameter word.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1048576: ARMED-state timeout in a_clk cycles (used only with the REQ-029 macro).
REQ-003 SHALL have port a_clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port a_resetn, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have ports h_valid/h_ready/h_addr/h_data, in/out/in/in, 1/1/3/DATA_WIDTH: host write channel.
REQ-006 SHALL have ports t_valid/t_ready/t_addr/t_data, in/out/in/in, 1/1/3/DATA_WIDTH: tracker write channel, same semantics as the host channel.
REQ-007 SHALL have port commit_req, input, 1: single-cycle request to commit the shadow registers to the live registers.
REQ-008 SHALL have port commit_immediate, input, 1: 1 = commit without waiting for sync_tick; sampled together with commit_req.
REQ-009 SHALL have port sync_tick, input, 1: scan-line boundary pulse from the GVP.
REQ-010 SHALL have ports x0, y0, z0, u0, rotmxx, rotmxy, slope_x, slope_y, output, DATA_WIDTH each: live registers, in address order 0..7.
REQ-011 SHALL have ports commit_pending/commit_done/commit_count/timeout_flag, out, 1/1/16/1: state != IDLE / one-cycle commit pulse / wrapping commit counter / sticky timeout indicator.

Function
REQ-012 SHALL hold eight shadow registers and eight live registers; an accepted write updates only the shadow register at addr.
REQ-013 SHALL accept at most one write per cycle; a handshake completes when valid and ready are both 1 in the same cycle.
REQ-014 SHALL drive ready from registered state only: ready = (state == IDLE) and channel granted; both ready signals are 0 in ARMED and COMMIT.
REQ-015 SHALL arbitrate round-robin: with a single valid, that channel is granted; with both valid, the channel opposite the last granted one wins; priority after reset favours host.
REQ-016 SHALL implement states IDLE, ARMED and COMMIT.
REQ-017 IDLE: commit_req & commit_immediate -> COMMIT; commit_req & !commit_immediate -> ARMED; sync_tick alone is ignored.
REQ-018 In IDLE, commit_req and sync_tick in the same cycle -> ARMED; that tick is not consumed.
REQ-019 ARMED: sync_tick -> COMMIT; commit_req is ignored.
REQ-020 COMMIT lasts exactly one cycle: live <= shadow (all eight words), commit_done = 1 in the following cycle, commit_count += 1 mod 2^16, next state IDLE.
REQ-021 A write accepted in the same IDLE cycle as commit_req SHALL be included in that commit.
REQ-022 Latency: commit_req (immediate) at cycle n -> COMMIT at n+1 -> new live values and commit_done visible at n+2; sync_tick in ARMED at cycle m -> live values visible at m+2.
REQ-023 Live registers SHALL change only on a COMMIT exit; they never show partially written state.
REQ-024 commit_done SHALL be 0 in every cycle other than the one following COMMIT.

Reset
REQ-025 With a_resetn = 0 at a clock edge, the block SHALL enter IDLE; commit_done = 0, commit_count = 0, timeout_flag = 0, round-robin priority = host.
REQ-026 Reset SHALL set shadow and live registers to 0, except rotmxx = 0x10000000 (1.0 in Q28).
REQ-027 Reset in ARMED or COMMIT SHALL discard the pending commit; live registers take their reset values.
REQ-028 Both ready outputs SHALL be 0 during reset and in the first cycle after reset.

Configuration
REQ-029 With macro SPM_PARAM_COMMIT_TIMEOUT_EN defined: a counter cleared on ARMED entry increments each ARMED cycle; at count TIMEOUT_CYCLES-1 the state goes to COMMIT and timeout_flag is set; timeout_flag clears on the next accepted commit_req.
REQ-030 Without SPM_PARAM_COMMIT_TIMEOUT_EN: ARMED waits indefinitely for sync_tick, timeout_flag is tied to 0, and no counter is synthesized.

Verification
REQ-031 Host writes addr0=0x00001000, then commit_req with commit_immediate=1 -> x0 = 0x00001000 two cycles later, commit_done pulses once, commit_count = 1.
REQ-032 Write addr7=0x0000ABCD, commit_req with commit_immediate=0, no tick for 50 cycles -> slope_y remains 0 and both ready = 0; sync_tick -> slope_y = 0x0000ABCD two cycles later.
REQ-033 h_valid and t_valid held for 4 cycles with distinct addresses -> grants alternate host, tracker, host, tracker.
REQ-034 commit_req and sync_tick in the same IDLE cycle (commit_immediate=0) -> ARMED; the commit happens only on the next sync_tick.
REQ-035 a_resetn = 0 during ARMED -> IDLE, rotmxx = 0x10000000, commit_count = 0, no commit_done pulse.
REQ-036 With macro defined and TIMEOUT_CYCLES=16, commit_req (non-immediate) with no tick -> commit after 16 ARMED cycles and timeout_flag = 1.

Source files
------------

// File: rtl/spm_param_commit.sv
// rtl/spm_param_commit.sv - shadow/live parameter bank with sync_tick-aligned commit
// Optional feature macro: SPM_PARAM_COMMIT_TIMEOUT_EN (ARMED-state timeout forcing a commit).
module spm_param_commit #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                  a_clk,
  input  logic                  a_resetn,
  input  logic                  h_valid,
  output logic                  h_ready,
  input  logic [2:0]            h_addr,
  input  logic [DATA_WIDTH-1:0] h_data,
  input  logic                  t_valid,
  output logic                  t_ready,
  input  logic [2:0]            t_addr,
  input  logic [DATA_WIDTH-1:0] t_data,
  input  logic                  commit_req,
  input  logic                  commit_immediate,
  input  logic                  sync_tick,
  output logic [DATA_WIDTH-1:0] x0,
  output logic [DATA_WIDTH-1:0] y0,
  output logic [DATA_WIDTH-1:0] z0,
  output logic [DATA_WIDTH-1:0] u0,
  output logic [DATA_WIDTH-1:0] rotmxx,
  output logic [DATA_WIDTH-1:0] rotmxy,
  output logic [DATA_WIDTH-1:0] slope_x,
  output logic [DATA_WIDTH-1:0] slope_y,
  output logic                  commit_pending,
  output logic                  commit_done,
  output logic [15:0]           commit_count,
  output logic                  timeout_flag
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  // rotmxx resets to 1.0 in Q28 so the rotation matrix starts as identity-like
  localparam logic [DATA_WIDTH-1:0] ROT_ONE = DATA_WIDTH'(32'h1000_0000);

  state_t                state;
  state_t                next_state;
  logic [DATA_WIDTH-1:0] shadow [8];
  logic [DATA_WIDTH-1:0] live   [8];
  logic                  ready_en;
  logic                  last_host;
  logic                  grant_host;
  logic                  grant_tracker;
  logic                  accept_en;
  logic                  h_fire;
  logic                  t_fire;
  logic                  timeout_hit;

  // a timeout of zero cycles has no meaning; stop elaboration early
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("spm_param_commit: TIMEOUT_CYCLES must be at least 1");
  end

  // writes are only taken in IDLE, and never in the first cycle out of reset
  assign accept_en = (state == S_IDLE) && ready_en;
  assign h_ready   = accept_en && grant_host;
  assign t_ready   = accept_en && grant_tracker;
  assign h_fire    = h_valid && h_ready;
  assign t_fire    = t_valid && t_ready;

  // round-robin grant: a lone requester wins, on contention the other side of the last winner
  always_comb begin
    grant_host    = 1'b0;
    grant_tracker = 1'b0;
    if (h_valid && t_valid) begin
      grant_host    = !last_host;
      grant_tracker = last_host;
    end else begin
      grant_host    = h_valid;
      grant_tracker = t_valid;
    end
  end

  // ready gating flop and round-robin history (reset leaves host favoured)
  always_ff @(posedge a_clk) begin
    if (!a_resetn) begin
      ready_en  <= 1'b0;
      last_host <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (h_fire) begin
        last_host <= 1'b1;
      end else if (t_fire) begin
        last_host <= 1'b0;
      end
    end
  end

  // shadow bank: the single accepted write of the cycle lands here
  always_ff @(posedge a_clk) begin
    if (!a_resetn) begin
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= (i == 4) ? ROT_ONE : '0;
      end
    end else if (h_fire) begin
      shadow[h_addr] <= h_data;
    end else if (t_fire) begin
      shadow[t_addr] <= t_data;
    end
  end

  // FSM state register
  always_ff @(posedge a_clk) begin
    if (!a_resetn) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next state; a tick coinciding with commit_req in IDLE only arms
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (commit_req) begin
          next_state = commit_immediate ? S_COMMIT : S_ARMED;
        end
      end
      S_ARMED: begin
        if (sync_tick || timeout_hit) begin
          next_state = S_COMMIT;
        end
      end
      S_COMMIT: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

`ifdef SPM_PARAM_COMMIT_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] to_cnt;
  logic             to_flag;

  assign timeout_hit  = (state == S_ARMED) && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_flag = to_flag;

  // ARMED dwell counter; held at zero outside ARMED so every entry starts fresh
  always_ff @(posedge a_clk) begin
    if (!a_resetn) begin
      to_cnt <= '0;
    end else if (state != S_ARMED) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // sticky timeout indicator, cleared when the next commit request is taken
  always_ff @(posedge a_clk) begin
    if (!a_resetn) begin
      to_flag <= 1'b0;
    end else if (timeout_hit) begin
      to_flag <= 1'b1;
    end else if ((state == S_IDLE) && commit_req) begin
      to_flag <= 1'b0;
    end
  end
`else
  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  // live bank copies the whole shadow bank in one edge when leaving COMMIT
  always_ff @(posedge a_clk) begin
    if (!a_resetn) begin
      for (int i = 0; i < 8; i++) begin
        live[i] <= (i == 4) ? ROT_ONE : '0;
      end
      commit_done  <= 1'b0;
      commit_count <= 16'd0;
    end else begin
      commit_done <= (state == S_COMMIT);
      if (state == S_COMMIT) begin
        for (int i = 0; i < 8; i++) begin
          live[i] <= shadow[i];
        end
        commit_count <= commit_count + 16'd1;
      end
    end
  end

  assign commit_pending = (state != S_IDLE);

  assign x0      = live[0];
  assign y0      = live[1];
  assign z0      = live[2];
  assign u0      = live[3];
  assign rotmxx  = live[4];
  assign rotmxy  = live[5];
  assign slope_x = live[6];
  assign slope_y = live[7];

endmodule
